// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an integrated transmit FIFO.
// Serialises FIFO words onto tx using an external OSR x baud tick.
//
// Parameters:
//   DATA_W     max data bits per frame (>= 5)
//   FIFO_DEPTH FIFO entries (power of 2, >= 2)
//   OSR        ticks per bit (>= 2)
// Ports:
//   clk, rst        clock, async active-high reset
//   tick            one-clk baud strobe at OSR x baud
//   wr_en, wr_data  FIFO push request and word (LSB sent first)
//   data_len        data bits per frame, clamped to 5..DATA_W at pop
//   stop_bit_num    0: 1 stop bit, 1: 2 stop bits
//   parity_en       append parity bit
//   parity_type     0: even, 1: odd
//   cts_n           active-low clear-to-send, checked at frame start
//   tx              registered serial line
//   rts_n           low while FIFO holds data
//   busy            high while a frame is in progress
//   tx_done         one-clk pulse at end of frame
//   full, empty     FIFO flags
//   level           FIFO occupancy
//   overflow        one-clk pulse when a push is dropped
//   send_break      only with UART_TX_BREAK_EN: hold tx low in IDLE
//
// Optional feature macro: UART_TX_BREAK_EN (adds send_break input).

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int OSR        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [$clog2(DATA_W):0]       data_len,
  input  logic                          stop_bit_num,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          cts_n,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          tx,
  output logic                          rts_n,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int LW = $clog2(DATA_W) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OSR);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a push to a
  // full FIFO is still accepted then.
  assign push = wr_en && (!full || pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= wr_en && full && !pop;
    end
  end

  // ---------------- Serialiser ----------------
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [LW-1:0]     bitcnt_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     len_c;
  logic [DATA_W-1:0] shreg_q;
  logic              par_q;
  logic              stop2_q;
  logic              pen_q;
  logic              ptype_q;
  logic              stopcnt_q;
  logic              tx_q;
  logic              done_q;
  logic              brk;
  logic              bit_end;
  logic              frame_end;
  logic              can_pop;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    len_c = data_len;
    if (data_len < LW'(5))
      len_c = LW'(5);
    else if (data_len > LW'(DATA_W))
      len_c = LW'(DATA_W);
  end

  assign bit_end   = tick && (cnt_q == CW'(OSR - 1));
  assign frame_end = (state_q == STOP) && bit_end &&
                     (stopcnt_q == stop2_q);
  assign can_pop   = tick && !empty && !cts_n && !brk;
  // Pop from IDLE, or on the final stop tick for
  // back-to-back frames without an idle bit.
  assign pop       = can_pop &&
                     ((state_q == IDLE) || frame_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      len_q     <= LW'(DATA_W);
      shreg_q   <= '0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
      pen_q     <= 1'b0;
      ptype_q   <= 1'b0;
      stopcnt_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        state_q   <= START;
        cnt_q     <= '0;
        shreg_q   <= head;
        len_q     <= len_c;
        stop2_q   <= stop_bit_num;
        pen_q     <= parity_en;
        ptype_q   <= parity_type;
        stopcnt_q <= 1'b0;
        tx_q      <= 1'b0;
        done_q    <= frame_end;
      end else if (tick) begin
        if (state_q != IDLE)
          cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
        unique case (state_q)
          IDLE: begin
            tx_q <= !brk;
          end
          START: begin
            if (bit_end) begin
              state_q  <= DATA;
              tx_q     <= shreg_q[0];
              par_q    <= shreg_q[0];
              shreg_q  <= shreg_q >> 1;
              bitcnt_q <= LW'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bitcnt_q == len_q) begin
                if (pen_q) begin
                  state_q <= PARITY;
                  tx_q    <= par_q ^ ptype_q;
                end else begin
                  state_q   <= STOP;
                  tx_q      <= 1'b1;
                  stopcnt_q <= 1'b0;
                end
              end else begin
                tx_q     <= shreg_q[0];
                par_q    <= par_q ^ shreg_q[0];
                shreg_q  <= shreg_q >> 1;
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              state_q   <= STOP;
              tx_q      <= 1'b1;
              stopcnt_q <= 1'b0;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (stopcnt_q == stop2_q) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
                tx_q    <= !brk;
              end else begin
                stopcnt_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = (state_q != IDLE);
  assign rts_n    = empty;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Frames captured mid-bit and compared to hand-built patterns.

module tb_uart_tx_fifo;

  localparam int OSR = 16;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [3:0] data_len;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       cts_n;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif
  logic       tx;
  logic       rts_n;
  logic       busy;
  logic       tx_done;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  int bad_edges = 0;

  uart_tx_fifo #(
    .DATA_W(8), .FIFO_DEPTH(8), .OSR(OSR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .data_len(data_len),
    .stop_bit_num(stop_bit_num),
    .parity_en(parity_en),
    .parity_type(parity_type),
    .cts_n(cts_n),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx(tx),
    .rts_n(rts_n),
    .busy(busy),
    .tx_done(tx_done),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick on every other rising edge
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ~tick;
    end
  end

  // tx may only move on an edge that carries a tick
  initial begin
    logic t, p;
    forever begin
      @(posedge clk);
      t = tick;
      p = tx;
      #1;
      if (tx !== p && !t) bad_edges++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Starts on the edge where tx is low (pop edge = tick 0),
  // samples each bit mid-period, records tick of tx_done.
  task automatic capture(input int nbits,
                         output logic [15:0] bits,
                         output int dn);
    int n;
    int cyc;
    logic t;
    bits = '0;
    dn   = -1;
    n    = 0;
    cyc  = 0;
    while (tx !== 1'b0 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (tx !== 1'b0) begin
      dn   = -2;
      bits = '1;
      return;
    end
    while (dn < 0 && cyc < 8000) begin
      @(posedge clk);
      t = tick;
      #1;
      cyc++;
      if (t) begin
        n++;
        for (int k = 0; k < nbits; k++)
          if (n == k * OSR + OSR / 2) bits[k] = tx;
      end
      if (tx_done === 1'b1) dn = n;
    end
  endtask

  initial begin
    logic [15:0] b;
    logic [7:0]  w;
    int          dn;
    int          c;
    logic        t;

    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    data_len     = 4'd8;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;
    parity_type  = 1'b0;
    cts_n        = 1'b1;
`ifdef UART_TX_BREAK_EN
    send_break   = 1'b0;
`endif

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_level", level, 4'd0);
    chk("rst_rts", rts_n, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // basic 8N1, 0xA5
    cts_n = 1'b0;
    push(8'hA5);
    c = 0;
    do begin
      @(posedge clk);
      t = tick;
      #1;
      c++;
    end while (!t && c < 10);
    chk("latency_tx", tx, 1'b0);
    capture(10, b, dn);
    chk("8n1_bits", b, 16'h034A);
    chk("8n1_done", dn, 160);
    @(posedge clk);
    #1;
    chk("8n1_done_pulse", tx_done, 1'b0);
    chk("8n1_idle_tx", tx, 1'b1);
    chk("8n1_busy", busy, 1'b0);

    // parity: 0x07, 7 bits, even, 1 stop
    @(negedge clk);
    cts_n     = 1'b1;
    data_len  = 4'd7;
    parity_en = 1'b1;
    push(8'h07);
    cts_n = 1'b0;
    capture(10, b, dn);
    chk("even_bits", b, 16'h030E);
    chk("even_done", dn, 10 * OSR);

    // odd, 2 stop bits
    @(negedge clk);
    cts_n        = 1'b1;
    parity_type  = 1'b1;
    stop_bit_num = 1'b1;
    push(8'h07);
    cts_n = 1'b0;
    capture(11, b, dn);
    chk("odd_bits", b, 16'h060E);
    chk("odd_done", dn, 11 * OSR);

    // FIFO fill and overflow
    @(negedge clk);
    cts_n        = 1'b1;
    data_len     = 4'd8;
    parity_en    = 1'b0;
    parity_type  = 1'b0;
    stop_bit_num = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("fill_ovf", overflow, 1'b1);
    chk("fill_full", full, 1'b1);
    chk("fill_level", level, 4'd8);
    chk("fill_rts", rts_n, 1'b0);
    @(negedge clk);
    chk("fill_ovf_pulse", overflow, 1'b0);
    cts_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      w = 8'(i);
      capture(10, b, dn);
      chk("b2b_bits", b, 32'({1'b1, w, 1'b0}));
      chk("b2b_done", dn, 160);
      if (i < 8) chk("b2b_no_idle", tx, 1'b0);
    end
    chk("b2b_end_tx", tx, 1'b1);
    chk("b2b_empty", empty, 1'b1);

    // latching and CTS
    @(negedge clk);
    cts_n = 1'b1;
    push(8'h3C);
    push(8'h15);
    fork
      capture(10, b, dn);
      begin
        cts_n = 1'b0;
        repeat (40) @(negedge clk);
        data_len = 4'd5;
        cts_n    = 1'b1;
      end
    join
    chk("latch_bits", b, 16'h0278);
    chk("latch_done", dn, 160);
    repeat (100) @(negedge clk);
    chk("cts_hold_tx", tx, 1'b1);
    chk("cts_hold_level", level, 4'd1);
    chk("cts_hold_busy", busy, 1'b0);
    cts_n = 1'b0;
    capture(7, b, dn);
    chk("len5_bits", b, 16'h006A);
    chk("len5_done", dn, 7 * OSR);

    // reset mid-frame
    @(negedge clk);
    cts_n    = 1'b1;
    data_len = 4'd8;
    push(8'h00);
    push(8'hAA);
    cts_n = 1'b0;
    c = 0;
    while (tx !== 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (60) @(negedge clk);
    chk("mid_tx", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_empty", empty, 1'b1);
    chk("arst_level", level, 4'd0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // clamp data_len 3 -> 5
    cts_n    = 1'b1;
    data_len = 4'd3;
    push(8'h16);
    cts_n = 1'b0;
    capture(7, b, dn);
    chk("clamp_bits", b, 16'h006C);
    chk("clamp_done", dn, 7 * OSR);

`ifdef UART_TX_BREAK_EN
    // break requested mid-frame
    @(negedge clk);
    cts_n    = 1'b1;
    data_len = 4'd8;
    push(8'h81);
    push(8'h42);
    fork
      capture(10, b, dn);
      begin
        cts_n = 1'b0;
        repeat (40) @(negedge clk);
        send_break = 1'b1;
      end
    join
    chk("brk_frame_bits", b, 16'h0302);
    chk("brk_frame_done", dn, 160);
    repeat (60) @(negedge clk);
    chk("brk_tx_low", tx, 1'b0);
    chk("brk_no_pop", level, 4'd1);
    chk("brk_busy", busy, 1'b0);
    cts_n      = 1'b1;
    send_break = 1'b0;
    repeat (10) @(negedge clk);
    chk("brk_release", tx, 1'b1);
    cts_n = 1'b0;
    capture(10, b, dn);
    chk("brk_next_bits", b, 16'h0284);
    chk("brk_next_done", dn, 160);
`endif

    chk("tx_only_on_tick", bad_edges, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, the next-generation serialiser for the UART datapath. It accepts words from the host bus side into a FIFO and serialises them onto `tx` at a rate set by an external baud `tick` and a configurable oversampling ratio. Each frame has 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits. The block also provides CTS-gated flow control and per-frame configuration latching.

## Interface
Parameters:
- `DATA_W`, default 8: maximum data bits per frame; must be ≥ 5.
- `FIFO_DEPTH`, default 8: FIFO entries; power of 2, ≥ 2.
- `OSR`, default 16: `tick` strobes per bit; must be ≥ 2.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk` baud strobe at OSR × baud rate.
- `wr_en` in 1: FIFO push request.
- `wr_data` in DATA_W: word to push; LSB is transmitted first.
- `data_len` in $clog2(DATA_W)+1: number of data bits.
- `stop_bit_num` in 1: 0 selects 1 stop bit, 1 selects 2.
- `parity_en` in 1: 1 appends a parity bit.
- `parity_type` in 1: 0 = even, 1 = odd.
- `cts_n` in 1: active-low clear-to-send from the far end.
- `tx` out 1: serial line, registered.
- `rts_n` out 1: low while the FIFO holds data.
- `busy` out 1: high while a frame is in progress.
- `tx_done` out 1: one-`clk` pulse at the end of a frame.
- `full`, `empty` out 1: FIFO status flags.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: one-`clk` pulse when a push is dropped.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Pop rule.** In IDLE, on a `tick` where `!empty && !cts_n`:
  - pop the head word into the shift register;
  - latch `data_len` (clamped to 5..DATA_W), `stop_bit_num`, `parity_en` and `parity_type`;
  - go to START.
- **Latched configuration.** Configuration inputs are sampled only at the pop. Changing them mid-frame does not affect the frame in progress.
- **Bit timing.** Every bit lasts exactly OSR ticks. The tick counter is $clog2(OSR) bits wide and clears on each bit boundary.
- **START:** `tx` = 0.
- **DATA:** `tx` = shift-register LSB. Shift right at each bit boundary. After `data_len` bits go to PARITY if parity is enabled, otherwise to STOP.
- **Parity bit** = XOR of the transmitted data bits, inverted when `parity_type` = 1. Only the low `data_len` bits contribute.
- **STOP:** `tx` = 1 for 1 or 2 bit periods, then return to IDLE. `tx_done` pulses on the `clk` of the final stop-bit tick.
- **CTS.** `cts_n` is checked only at frame start. Deasserting it mid-frame does not abort the frame.
- **Back-to-back frames.** If the FIFO is non-empty and CTS is asserted on the final stop tick, the next word is popped on that same tick and START follows immediately, with no idle bit in between.
- **FIFO push rule.**
  - A push is accepted when `!full`, or when a pop occurs in the same cycle; the pop frees the slot.
  - A push while `full` with no simultaneous pop is dropped and pulses `overflow`.
  - A push to an empty FIFO is never lost.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `level` increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- **Status outputs.**
  - `rts_n` = `empty`.
  - `busy` is high in every state except IDLE.

## Timing
- **Reset values:** `tx` = 1, `tx_done` = 0, `busy` = 0, `overflow` = 0, `full` = 0, `empty` = 1, `level` = 0, `rts_n` = 1; FSM in IDLE.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, the FIFO is flushed and the partial frame is discarded.
- **Line output:** `tx` is a flop and changes only on a `clk` edge where `tick` = 1.
- **Frame length:** OSR × (1 + data_len + parity_en + stop bits) ticks from pop to the `tx_done` pulse.
- **Push latency:**
  - `full`, `empty` and `level` update on the `clk` after a push or pop.
  - Minimum latency from the first push into an empty FIFO to `tx` falling is the next `tick` after the write edge.
- **Ticks outside IDLE-with-data:** `tick` has no effect on the FIFO. `tick` strobes in IDLE with an empty FIFO are ignored.

## Configuration
- Macro `UART_TX_BREAK_EN`.
- **Defined:**
  - adds input `send_break` (1 bit);
  - while `send_break` is high in IDLE, `tx` is driven 0 and no pop occurs;
  - asserting `send_break` mid-frame takes effect only after the current frame's `tx_done`.
- **Undefined:** the port is absent and `tx` follows the frame FSM only.

## Test plan
- **Basic 8N1 frame.** Reset, OSR = 16, push 0xA5, `data_len` = 8, no parity, 1 stop bit, `cts_n` = 0.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held for 16 ticks.
  - One `tx_done` pulse at tick 160.
- **Parity.** Push 0x07, `data_len` = 7, even parity, then odd parity.
  - Parity bit = 1 for even, 0 for odd.
  - Frame lengths are 10 bit periods with 1 stop bit and 11 with 2.
- **FIFO fill and overflow.** Hold `cts_n` = 1 and push 9 words at DEPTH = 8.
  - `full` = 1 and `level` = 8.
  - The 9th push pulses `overflow`.
  - Releasing `cts_n` transmits the 8 words back-to-back with no idle bits between frames.
- **Latching and CTS.** Change `data_len` 8→5 and raise `cts_n` mid-frame.
  - The current frame completes at 8 bits.
  - The next frame does not start until `cts_n` = 0, then uses 5 bits.
- **Reset and clamping.** Assert `rst` during DATA, then `data_len` = 3.
  - After reset, `tx` = 1 immediately and `empty` = 1.
  - With `data_len` = 3, frames carry 5 data bits.
- **Break (`UART_TX_BREAK_EN` defined).** Set `send_break` = 1 during a frame.
  - The frame finishes first.
  - `tx` is then held 0 until `send_break` = 0, and the FIFO does not pop during the break.
